// File: rtl/servo_seq_sched.sv
// Frame scheduler and slew limiter for the servo PWM bank.
// Holds one target per channel (host valid/ready writes) and, once per frame,
// walks all channels one per cycle moving each current position toward its target.
// Optional feature macro: SERVO_SEQ_SLEW_EN (defined: slew-limited by STEP per frame;
// undefined: the walk copies target to current directly).
module servo_seq_sched #(
  parameter int unsigned SERVO_CNT    = 18,
  parameter int unsigned RESOLUTION   = 8,
  parameter int unsigned FRAME_CYCLES = 1000000,
  parameter int unsigned STEP         = 4,
  parameter int unsigned RESET_POS    = 128,
  localparam int unsigned ADDR_W      = $clog2(SERVO_CNT)
) (
  input  logic                            clk,
  input  logic                            res,
  input  logic                            wr_valid,
  output logic                            wr_ready,
  input  logic [ADDR_W-1:0]               wr_addr,
  input  logic [RESOLUTION-1:0]           wr_data,
  output logic                            wr_err,
  output logic [SERVO_CNT*RESOLUTION-1:0] servo_data,
  output logic                            frame_tick,
  output logic                            busy,
  output logic                            settled
);

  localparam int unsigned CNT_W = $clog2(FRAME_CYCLES);

`ifdef SERVO_SEQ_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0]             CNT_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [ADDR_W-1:0]            IDX_LAST = ADDR_W'(SERVO_CNT - 1);
  localparam logic [RESOLUTION-1:0]        POS_RST  = RESOLUTION'(RESET_POS);
  localparam logic [RESOLUTION-1:0]        STEP_U   = RESOLUTION'(STEP);
  localparam logic signed [RESOLUTION:0]   STEP_POS = $signed((RESOLUTION+1)'(STEP));
  localparam logic signed [RESOLUTION:0]   STEP_NEG = -STEP_POS;

  typedef enum logic {IDLE, UPDATE} state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_W-1:0]       idx_q;
  logic [RESOLUTION-1:0]   tgt_q [SERVO_CNT];
  logic [RESOLUTION-1:0]   cur_q [SERVO_CNT];
  logic                    wr_ready_q;
  logic                    wr_err_q;
  logic                    frame_tick_q;
  logic                    busy_q;
  logic                    settled_q;

  logic                    accept;
  logic                    addr_ok;
  logic                    frame_wrap;
  logic [CNT_W-1:0]        cnt_d;
  logic [RESOLUTION-1:0]   cur_sel;
  logic [RESOLUTION-1:0]   tgt_sel;
  logic signed [RESOLUTION:0] diff;
  logic [RESOLUTION-1:0]   slewed;
  logic [RESOLUTION-1:0]   cur_d;
  logic                    all_eq_d;

  assign accept     = wr_valid && wr_ready_q;
  assign addr_ok    = 32'(wr_addr) < SERVO_CNT;
  assign frame_wrap = (cnt_q == CNT_LAST);
  assign cnt_d      = frame_wrap ? '0 : cnt_q + CNT_W'(1);

  // Next value for the channel being walked: step toward target without overshoot.
  always_comb begin
    cur_sel = cur_q[idx_q];
    tgt_sel = tgt_q[idx_q];
    diff    = $signed({1'b0, tgt_sel}) - $signed({1'b0, cur_sel});
    slewed  = tgt_sel;
    if (diff > STEP_POS) begin
      slewed = cur_sel + STEP_U;
    end else if (diff < STEP_NEG) begin
      slewed = cur_sel - STEP_U;
    end
    cur_d = SLEW_EN ? slewed : tgt_sel;
  end

  // Compare every current position with its target.
  always_comb begin
    all_eq_d = 1'b1;
    for (int i = 0; i < int'(SERVO_CNT); i++) begin
      if (cur_q[i] != tgt_q[i]) all_eq_d = 1'b0;
    end
  end

  // Frame counter, host writes, update walk FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      wr_ready_q   <= 1'b1;
      wr_err_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      busy_q       <= 1'b0;
      settled_q    <= 1'b1;
      for (int i = 0; i < int'(SERVO_CNT); i++) begin
        tgt_q[i] <= POS_RST;
        cur_q[i] <= POS_RST;
      end
    end else begin
      cnt_q     <= cnt_d;
      wr_err_q  <= accept && !addr_ok;
      settled_q <= all_eq_d;
      if (accept && addr_ok) tgt_q[wr_addr] <= wr_data;
      case (state_q)
        IDLE: begin
          frame_tick_q <= 1'b0;
          if (frame_wrap) begin
            state_q      <= UPDATE;
            idx_q        <= '0;
            busy_q       <= 1'b1;
            wr_ready_q   <= 1'b0;
            frame_tick_q <= 1'b1;
          end
        end
        UPDATE: begin
          cur_q[idx_q] <= cur_d;
          frame_tick_q <= 1'b0;
          if (idx_q == IDX_LAST) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b1;
          end else begin
            idx_q <= idx_q + ADDR_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Flatten current positions onto the PWM bank bus.
  for (genvar g = 0; g < int'(SERVO_CNT); g++) begin : g_pack
    assign servo_data[g*RESOLUTION +: RESOLUTION] = cur_q[g];
  end

  assign wr_ready   = wr_ready_q;
  assign wr_err     = wr_err_q;
  assign frame_tick = frame_tick_q;
  assign busy       = busy_q;
  assign settled    = settled_q;

endmodule
